// File: rtl/dmem_arbiter_if.sv
// Purpose : bundle of the two requester ports and the data-memory side of dmem_arbiter.
// Latency : n/a (wires only); slave = arbiter view, master = requesters + memory view.
// Backpr. : req*_i held by a requester until its gnt*_o; the memory never stalls.
// Ports   : req/we/lock/addr/wdata per requester in, gnt/rvalid/rdata per requester out,
//           dmem_addr/wr_en/rd_en/wdata to memory, dmem_rdata from memory, lock_timeout pulse.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // requester 0 (core LSU)
  logic          req0_i;
  logic          we0_i;
  logic          lock0_i;
  logic [AW-1:0] addr0_i;
  logic [DW-1:0] wdata0_i;
  logic          gnt0_o;
  logic          rvalid0_o;
  logic [DW-1:0] rdata0_o;
  // requester 1 (debug / DMA)
  logic          req1_i;
  logic          we1_i;
  logic          lock1_i;
  logic [AW-1:0] addr1_i;
  logic [DW-1:0] wdata1_i;
  logic          gnt1_o;
  logic          rvalid1_o;
  logic [DW-1:0] rdata1_o;
  // memory side
  logic [AW-1:0] dmem_addr_o;
  logic          dmem_wr_en_o;
  logic          dmem_rd_en_o;
  logic [DW-1:0] dmem_wdata_o;
  logic [DW-1:0] dmem_rdata_i;
  logic          lock_timeout_o;

  modport slave (
    input  req0_i, we0_i, lock0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, lock1_i, addr1_i, wdata1_i,
    input  dmem_rdata_i,
    output gnt0_o, rvalid0_o, rdata0_o,
    output gnt1_o, rvalid1_o, rdata1_o,
    output dmem_addr_o, dmem_wr_en_o, dmem_rd_en_o, dmem_wdata_o,
    output lock_timeout_o
  );

  modport master (
    output req0_i, we0_i, lock0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, lock1_i, addr1_i, wdata1_i,
    output dmem_rdata_i,
    input  gnt0_o, rvalid0_o, rdata0_o,
    input  gnt1_o, rvalid1_o, rdata1_o,
    input  dmem_addr_o, dmem_wr_en_o, dmem_rd_en_o, dmem_wdata_o,
    input  lock_timeout_o
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose : two-port arbiter in front of a single-port data memory, with bounded bus lock.
// Latency : grant and memory strobes combinational; read data + rvalid one cycle after grant.
// Backpr. : losing/locked-out port sees gnt low and must hold its request until granted.
// Ports   : clk_i, rst_ni (async, active low), bus (dmem_arbiter_if.slave).
// Config  : DMEM_ARB_RR_EN defined -> round-robin on conflicts in IDLE (1-bit last-grant
//           pointer, reset so port 0 wins the first conflict); undefined -> port 0 always wins.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_LOCK_CYC = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  bus
);

  localparam int CW = (MAX_LOCK_CYC > 2) ? $clog2(MAX_LOCK_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LOCK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          gnt0, gnt1;
  logic          any_gnt, sel_we;
  logic [AW-1:0] mux_addr;
  logic [DW-1:0] mux_wdata;
  logic          lock_release, at_limit, lock_timeout;

`ifdef DMEM_ARB_RR_EN
  // 1 = port 1 was granted last, so port 0 wins the next conflict
  logic last_q, last_d;
`endif

  // Grant decode: lock owner is exclusive; IDLE resolves conflicts by priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0_i && bus.req1_i) begin
`ifdef DMEM_ARB_RR_EN
          gnt0 = last_q;
          gnt1 = ~last_q;
`else
          gnt0 = 1'b1;
`endif
        end else begin
          gnt0 = bus.req0_i;
          gnt1 = bus.req1_i;
        end
      end
      LOCK0:   gnt0 = bus.req0_i;
      LOCK1:   gnt1 = bus.req1_i;
      default: ;
    endcase
    // no strobes while reset is asserted, whatever the requesters drive
    if (!rst_ni) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Memory mux: idle bus is driven to zero rather than left on a stale port.
  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt0 ? bus.we0_i : bus.we1_i;
    mux_addr  = '0;
    mux_wdata = '0;
    if (gnt0) begin
      mux_addr  = bus.addr0_i;
      mux_wdata = bus.wdata0_i;
    end else if (gnt1) begin
      mux_addr  = bus.addr1_i;
      mux_wdata = bus.wdata1_i;
    end
  end

  // Lock FSM next state. The counter counts cycles spent in LOCKn starting at 0; when it
  // sits at MAX_LOCK_CYC-1 the lock is forced off, unless the owner releases it itself in
  // that same cycle. An access granted in the final cycle still goes to memory normally.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_release = ((state_q == LOCK0) && gnt0 && !bus.lock0_i) ||
                   ((state_q == LOCK1) && gnt1 && !bus.lock1_i);
    at_limit     = (state_q != IDLE) && (cnt_q == CNT_LAST);
    lock_timeout = at_limit && !lock_release;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt0 && bus.lock0_i)      state_d = LOCK0;
        else if (gnt1 && bus.lock1_i) state_d = LOCK1;
      end
      default: begin
        if (lock_release || at_limit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Read return: capture memory data on a read grant, otherwise hold the last value.
  always_comb begin
    rvalid0_d = gnt0 & ~bus.we0_i;
    rvalid1_d = gnt1 & ~bus.we1_i;
    rdata0_d  = rvalid0_d ? bus.dmem_rdata_i : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.dmem_rdata_i : rdata1_q;
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (gnt1)      last_d = 1'b1;
    else if (gnt0) last_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.gnt0_o         = gnt0;
  assign bus.gnt1_o         = gnt1;
  assign bus.rvalid0_o      = rvalid0_q;
  assign bus.rvalid1_o      = rvalid1_q;
  assign bus.rdata0_o       = rdata0_q;
  assign bus.rdata1_o       = rdata1_q;
  assign bus.dmem_addr_o    = mux_addr;
  assign bus.dmem_wdata_o   = mux_wdata;
  assign bus.dmem_wr_en_o   = any_gnt & sel_we;
  assign bus.dmem_rd_en_o   = any_gnt & ~sel_we;
  assign bus.lock_timeout_o = lock_timeout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose : self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
//           checked against a transaction-level model of arbitration, locking and memory.
// Latency : inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpr. : bench requesters hold each request until granted.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_mem = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK_CYC(MAXL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // memory: combinational read, write on rising edge
  logic [31:0] mem [0:255];
  assign bus.dmem_rdata_i = mem[bus.dmem_addr_o[9:2]];
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bus.dmem_wr_en_o) begin
      mem[bus.dmem_addr_o[9:2]] <= bus.dmem_wdata_o;
    end
  end

  task automatic set_p0(input logic req, input logic we, input logic lock,
                        input logic [31:0] a, input logic [31:0] d);
    bus.req0_i = req; bus.we0_i = we; bus.lock0_i = lock; bus.addr0_i = a; bus.wdata0_i = d;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic lock,
                        input logic [31:0] a, input logic [31:0] d);
    bus.req1_i = req; bus.we1_i = we; bus.lock1_i = lock; bus.addr1_i = a; bus.wdata1_i = d;
  endtask

  task automatic idle_inputs();
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_mem = 1'b1;
    set_p0(1'b1, 1'b0, 1'b1, 32'h10, 32'h1);
    set_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'h2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 00", {bus.gnt0_o, bus.gnt1_o});
    end
    n_tests++;
    if ({bus.dmem_wr_en_o, bus.dmem_rd_en_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_en: got %b expected 00", {bus.dmem_wr_en_o, bus.dmem_rd_en_o});
    end
    n_tests++;
    if ({bus.rvalid0_o, bus.rvalid1_o, bus.lock_timeout_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rvalid_to: got %b expected 000",
                         {bus.rvalid0_o, bus.rvalid1_o, bus.lock_timeout_o});
    end
    n_tests++;
    if ({bus.rdata0_o, bus.rdata1_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", {bus.rdata0_o, bus.rdata1_o});
    end
    n_tests++;
    if (bus.dmem_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.dmem_addr_o);
    end
    clear_mem = 1'b0;
    idle_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    set_p0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.dmem_wr_en_o, bus.dmem_rd_en_o} !== 4'b1010) begin
      n_fail++; $display("FAIL wr_gnt: got %b expected 1010",
                         {bus.gnt0_o, bus.gnt1_o, bus.dmem_wr_en_o, bus.dmem_rd_en_o});
    end
    n_tests++;
    if ({bus.dmem_addr_o, bus.dmem_wdata_o} !== {32'h10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_bus: got %h expected 00000010deadbeef",
                         {bus.dmem_addr_o, bus.dmem_wdata_o});
    end
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.rvalid0_o} !== 5'b10010) begin
      n_fail++; $display("FAIL rd_gnt: got %b expected 10010",
                         {bus.gnt0_o, bus.gnt1_o, bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.rvalid0_o});
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if ({bus.rvalid0_o, bus.rdata0_o} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL rd_data: got %b/%h expected 1/deadbeef", bus.rvalid0_o, bus.rdata0_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({bus.rvalid0_o, bus.rdata0_o} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL rd_hold: got %b/%h expected 0/deadbeef", bus.rvalid0_o, bus.rdata0_o);
    end
  endtask

  task automatic test_conflict();
    logic [1:0] exp_g;
    do_reset();
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_p1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      n_tests++;
      if ({bus.gnt0_o, bus.gnt1_o} !== exp_g) begin
        n_fail++; $display("FAIL rr_cycle%0d: got %b expected %b", i, {bus.gnt0_o, bus.gnt1_o}, exp_g);
      end
      @(posedge clk); #1;
    end
`else
    exp_g = 2'b10;
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o} !== exp_g) begin
      n_fail++; $display("FAIL prio_cycle0: got %b expected %b", {bus.gnt0_o, bus.gnt1_o}, exp_g);
    end
    @(posedge clk); #1;
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    exp_g = 2'b01;
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o} !== exp_g) begin
      n_fail++; $display("FAIL prio_cycle1: got %b expected %b", {bus.gnt0_o, bus.gnt1_o}, exp_g);
    end
    @(posedge clk); #1;
`endif
    idle_inputs();
  endtask

  task automatic test_lock_release();
    @(posedge clk); #1;
    set_p1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o} !== 2'b01) begin
      n_fail++; $display("FAIL lock1_gnt: got %b expected 01", {bus.gnt0_o, bus.gnt1_o});
    end
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    set_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.dmem_wr_en_o} !== 3'b011) begin
      n_fail++; $display("FAIL lock1_stall: got %b expected 011",
                         {bus.gnt0_o, bus.gnt1_o, bus.dmem_wr_en_o});
    end
    n_tests++;
    if ({bus.rvalid1_o, bus.rdata1_o} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL lock1_rd: got %b/%h expected 1/00000000", bus.rvalid1_o, bus.rdata1_o);
    end
    @(posedge clk); #1;
    set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.dmem_rd_en_o} !== 3'b101) begin
      n_fail++; $display("FAIL lock1_exit: got %b expected 101",
                         {bus.gnt0_o, bus.gnt1_o, bus.dmem_rd_en_o});
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_tests++;
    if ({bus.rvalid0_o, bus.rdata0_o} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL lock1_p0data: got %b/%h expected 1/deadbeef", bus.rvalid0_o, bus.rdata0_o);
    end
  endtask

  task automatic test_lock_timeout();
    logic [2:0] exp_v;
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o} !== 3'b100) begin
      n_fail++; $display("FAIL to_lock_gnt: got %b expected 100",
                         {bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o});
    end
    @(posedge clk); #1;
    set_p0(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    for (int k = 1; k <= MAXL; k++) begin
      exp_v = {2'b00, (k == MAXL)};
      @(negedge clk);
      n_tests++;
      if ({bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o} !== exp_v) begin
        n_fail++; $display("FAIL to_cycle%0d: got %b expected %b", k,
                           {bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o}, exp_v);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o} !== 3'b010) begin
      n_fail++; $display("FAIL to_after: got %b expected 010",
                         {bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_lock();
    @(posedge clk); #1;
    set_p0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o} !== 2'b10) begin
      n_fail++; $display("FAIL rst_lock_gnt: got %b expected 10", {bus.gnt0_o, bus.gnt1_o});
    end
    @(posedge clk); #1;
    set_p1(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o, bus.rvalid0_o} !== 3'b101) begin
      n_fail++; $display("FAIL rst_locked_rd: got %b expected 101",
                         {bus.gnt0_o, bus.gnt1_o, bus.rvalid0_o});
    end
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.rvalid0_o, bus.rvalid1_o, bus.gnt0_o, bus.gnt1_o,
         bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.lock_timeout_o} !== 7'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b expected 0000000",
                         {bus.rvalid0_o, bus.rvalid1_o, bus.gnt0_o, bus.gnt1_o,
                          bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.lock_timeout_o});
    end
    n_tests++;
    if ({bus.rdata0_o, bus.rdata1_o, bus.dmem_addr_o} !== 96'h0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h expected 0", {bus.rdata0_o, bus.rdata1_o, bus.dmem_addr_o});
    end
    set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0_o, bus.gnt1_o} !== 2'b10) begin
      n_fail++; $display("FAIL rst_first_conflict: got %b expected 10", {bus.gnt0_o, bus.gnt1_o});
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Random traffic against a transaction-level model: who owns the bus, how long the lock
  // has been held, what the memory holds, and which read result is due next cycle.
  task automatic test_random();
    logic        p_req [2], p_we [2], p_lock [2];
    logic [31:0] p_addr [2], p_wd [2];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd [2];
    logic        pend [2];
    logic        last, eg0, eg1, et, releasing;
    int          owner, age, gi, rate;

    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    for (int n = 0; n < 2; n++) begin
      p_req[n] = 1'b0; p_we[n] = 1'b0; p_lock[n] = 1'b0;
      p_addr[n] = 32'h0; p_wd[n] = 32'h0; exp_rd[n] = 32'h0; pend[n] = 1'b0;
    end
    owner = -1; age = 0; last = 1'b1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      rate = ((cyc / 100) % 2 == 0) ? 7 : 2;
      for (int n = 0; n < 2; n++) begin
        if (!p_req[n] && $urandom_range(0, 9) < rate) begin
          p_req[n]  = 1'b1;
          p_we[n]   = $urandom_range(0, 1) == 1;
          p_lock[n] = $urandom_range(0, 3) == 0;
          p_addr[n] = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          p_wd[n]   = $urandom;
        end
      end
      set_p0(p_req[0], p_we[0], p_lock[0], p_addr[0], p_wd[0]);
      set_p1(p_req[1], p_we[1], p_lock[1], p_addr[1], p_wd[1]);

      eg0 = 1'b0; eg1 = 1'b0;
      if (owner < 0) begin
        if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_RR_EN
          if (last) eg0 = 1'b1; else eg1 = 1'b1;
`else
          eg0 = 1'b1;
`endif
        end else begin
          eg0 = p_req[0]; eg1 = p_req[1];
        end
      end else if (owner == 0) begin
        eg0 = p_req[0];
      end else begin
        eg1 = p_req[1];
      end
      gi = eg0 ? 0 : (eg1 ? 1 : -1);
      releasing = (owner >= 0) && (gi == owner) && !p_lock[owner];
      et = (owner >= 0) && (age == MAXL) && !releasing;

      @(negedge clk);
      n_tests++;
      if ({bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o, bus.rvalid0_o, bus.rvalid1_o} !==
          {eg0, eg1, et, pend[0], pend[1]}) begin
        n_fail++; $display("FAIL rnd_ctrl@%0d: got %b expected %b (gnt0 gnt1 timeout rvalid0 rvalid1)", cyc,
                           {bus.gnt0_o, bus.gnt1_o, bus.lock_timeout_o, bus.rvalid0_o, bus.rvalid1_o},
                           {eg0, eg1, et, pend[0], pend[1]});
      end
      n_tests++;
      if ({bus.rdata0_o, bus.rdata1_o} !== {exp_rd[0], exp_rd[1]}) begin
        n_fail++; $display("FAIL rnd_rdata@%0d: got %h/%h expected %h/%h", cyc,
                           bus.rdata0_o, bus.rdata1_o, exp_rd[0], exp_rd[1]);
      end
      n_tests++;
      if (gi >= 0) begin
        if ({bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.dmem_addr_o, bus.dmem_wdata_o} !==
            {p_we[gi], !p_we[gi], p_addr[gi], p_wd[gi]}) begin
          n_fail++; $display("FAIL rnd_membus@%0d: got %b%b %h %h expected %b%b %h %h", cyc,
                             bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.dmem_addr_o, bus.dmem_wdata_o,
                             p_we[gi], !p_we[gi], p_addr[gi], p_wd[gi]);
        end
      end else begin
        if ({bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.dmem_addr_o, bus.dmem_wdata_o} !== 66'h0) begin
          n_fail++; $display("FAIL rnd_membus_idle@%0d: got %b%b %h %h expected all zero", cyc,
                             bus.dmem_wr_en_o, bus.dmem_rd_en_o, bus.dmem_addr_o, bus.dmem_wdata_o);
        end
      end

      // effects of this cycle's access at the coming edge
      pend[0] = 1'b0; pend[1] = 1'b0;
      if (gi >= 0) begin
        if (p_we[gi]) begin
          ref_mem[p_addr[gi][5:2]] = p_wd[gi];
        end else begin
          pend[gi]   = 1'b1;
          exp_rd[gi] = ref_mem[p_addr[gi][5:2]];
        end
        p_req[gi] = 1'b0;
        last = (gi == 1);
      end
      if (owner < 0) begin
        if (gi >= 0 && p_lock[gi]) begin
          owner = gi; age = 1;
        end
      end else if (releasing || et) begin
        owner = -1; age = 0;
      end else begin
        age++;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_conflict();
    test_lock_release();
    test_lock_timeout();
    test_reset_mid_lock();
    test_random();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
